chroma_bg_fetch: RTL and testbench

Background-image fetch engine for the chroma-key path. It streams one frame of stored background pixels from external memory over a pipelined read master and buffers them in a small FIFO. It delivers one 30-bit RGB pixel per consumer request, so the compositor always has the background pixel aligned with the live video pixel. It is the producer end of the background-pixel interface (imVGA_R/G/B) that the chroma compositor consumes.

---
 rtl/chroma_bg_fetch.sv | 162 ++++++++++++++++
 tb/tb_chroma_bg_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/chroma_bg_fetch.sv
// Background-frame fetch engine: streams H_ACTIVE*V_ACTIVE words over a pipelined read master into a pixel FIFO.
// Build option BG_UNDERFLOW_HOLD_EN: an empty-FIFO request repeats the last pixel instead of driving zero.
module chroma_bg_fetch #(
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          FIFO_DEPTH = 16,
  parameter int          ADDR_W     = 19
) (
  input  logic              iCLK27,
  input  logic              iRST,
  input  logic              iFrameStart,
  input  logic              iPixReq,
  output logic [9:0]        oVGA_R,
  output logic [9:0]        oVGA_G,
  output logic [9:0]        oVGA_B,
  output logic              oUnderflow,
  output logic              oMemRead,
  output logic [ADDR_W-1:0] oMemAddr,
  input  logic              iMemWaitRequest,
  input  logic              iMemReadDataValid,
  input  logic [31:0]       iMemReadData
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [LVL_W-1:0]  DEPTH     = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE, DRAIN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    word_cnt;
  logic [LVL_W-1:0]    inflight;
  logic [LVL_W-1:0]    fifo_cnt;
  logic [LVL_W-1:0]    discard;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [29:0]         fifo_mem [FIFO_DEPTH];
  logic [29:0]         pix_p1;
  logic                hold_req;
  logic                underflow;
  logic                mem_read;
  logic [ADDR_W-1:0]   mem_addr;

  logic                accept, stall, ret, push, pop, fifo_empty;
  logic                last_accept, drain_done, fetch_nxt, hold_nxt;
  logic [LVL_W-1:0]    inflight_nxt, fifo_cnt_nxt, orphans;
  logic [LVL_W:0]      credit_sum;
  logic                unused_data;

  assign unused_data = ^iMemReadData[31:30];

  always_comb begin
    accept       = mem_read & ~iMemWaitRequest;
    stall        = mem_read & iMemWaitRequest;
    ret          = iMemReadDataValid & (state != IDLE);
    push         = ret & (state != DRAIN);
    fifo_empty   = (fifo_cnt == '0);
    pop          = iPixReq & ~fifo_empty;
    inflight_nxt = inflight + LVL_W'(accept) - LVL_W'(ret);
    fifo_cnt_nxt = iFrameStart ? '0 : fifo_cnt + LVL_W'(push) - LVL_W'(pop);
    // A request stalled across a restart still owes the slave its handshake; its data is stale.
    orphans      = inflight_nxt + LVL_W'(stall);
    last_accept  = accept & ~hold_req & (state == FETCH) & (word_cnt == LAST_WORD);
    drain_done   = (state == DRAIN) & ret & (discard == LVL_W'(1));
    fetch_nxt    = ((state == FETCH) & ~last_accept) | drain_done;
    hold_nxt     = hold_req & ~accept;
    credit_sum   = {1'b0, fifo_cnt_nxt} + {1'b0, inflight_nxt};
  end

  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      word_cnt  <= '0;
      inflight  <= '0;
      fifo_cnt  <= '0;
      discard   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      hold_req  <= 1'b0;
      underflow <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= BASE;
    end else begin
      inflight <= inflight_nxt;
      fifo_cnt <= fifo_cnt_nxt;
      if (iFrameStart) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        underflow <= 1'b0;
        word_cnt  <= '0;
        hold_req  <= stall;
        if (!stall) mem_addr <= BASE;
        if (orphans != '0) begin
          state    <= DRAIN;
          discard  <= orphans;
          mem_read <= stall;
        end else begin
          state    <= FETCH;
          mem_read <= 1'b1;
        end
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (iPixReq && fifo_empty) underflow <= 1'b1;
        hold_req <= hold_nxt;
        if (hold_req && accept) mem_addr <= BASE;
        case (state)
          FETCH: begin
            if (accept && !hold_req) begin
              word_cnt <= word_cnt + CNT_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
              if (last_accept) state <= DONE;
            end
          end
          DRAIN: begin
            if (ret) begin
              discard <= discard - LVL_W'(1);
              if (drain_done) state <= FETCH;
            end
          end
          default: ;
        endcase
        // Credit is evaluated on next-cycle occupancy so the registered request never overcommits.
        mem_read <= hold_nxt | (fetch_nxt & (credit_sum < (LVL_W+1)'(FIFO_DEPTH)));
      end
    end
  end

  always_ff @(posedge iCLK27) begin
    if (push) fifo_mem[wr_ptr] <= iMemReadData[29:0];
  end

  // Output pixel stage
  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      pix_p1 <= '0;
    end else if (pop) begin
      pix_p1 <= fifo_mem[rd_ptr];
`ifdef BG_UNDERFLOW_HOLD_EN
    end
`else
    end else if (iPixReq) begin
      pix_p1 <= '0;
    end
`endif
  end

  assert property (@(posedge iCLK27) disable iff (iRST) !(push && (fifo_cnt == DEPTH)));

  assign oVGA_R     = pix_p1[29:20];
  assign oVGA_G     = pix_p1[19:10];
  assign oVGA_B     = pix_p1[9:0];
  assign oUnderflow = underflow;
  assign oMemRead   = mem_read;
  assign oMemAddr   = mem_addr;

endmodule

// File: tb/tb_chroma_bg_fetch.sv
// Directed bench for chroma_bg_fetch with a pipelined memory slave (data = address) and a pixel-order model.
module tb_chroma_bg_fetch;
  localparam int H = 16;
  localparam int V = 8;
  localparam int D = 16;
  localparam int AW = 19;
  localparam int LAT = 3;
  localparam logic [AW-1:0] BASE = 19'h7FFC0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, fs = 1'b0, req = 1'b0;
  logic [9:0] vr, vg, vb;
  logic uf, mrd, mwait = 1'b0, rvalid = 1'b0;
  logic [AW-1:0] maddr;
  logic [31:0] rdata = '0;

  chroma_bg_fetch #(.BASE_ADDR(BASE), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
    .iCLK27(clk), .iRST(rst), .iFrameStart(fs), .iPixReq(req),
    .oVGA_R(vr), .oVGA_G(vg), .oVGA_B(vb), .oUnderflow(uf),
    .oMemRead(mrd), .oMemAddr(maddr), .iMemWaitRequest(mwait),
    .iMemReadDataValid(rvalid), .iMemReadData(rdata));

  typedef struct { int due; logic [AW-1:0] a; bit stale; } rd_t;
  rd_t pend[$];
  logic [29:0] model_q[$];

  int tests = 0, fails = 0, cyc = 0;
  int wait_left = 0, acc_cnt = 0, first_acc = 0, last_acc = 0;
  bit rnd_wait = 0, ret_block = 0, stall_arm = 0, hold_stale = 0;
  logic [AW-1:0] stall_addr = '0, exp_addr = BASE;
  logic [29:0] exp_pix = '0, last_pix = '0;
  logic exp_uf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs and slave response for the next edge, then check after it.
  task automatic tick(input bit pr, input bit f);
    rd_t e;
    bit acc, rv, r_stale;
    logic [AW-1:0] r_a;
    req = pr;
    fs = f;
    if (stall_arm && mrd && maddr == stall_addr) begin
      wait_left = 5;
      stall_arm = 0;
    end
    if (wait_left > 0) begin
      mwait = 1'b1;
      check("stall_addr", 32'(maddr), 32'(stall_addr));
      check("stall_rd", 32'(mrd), 32'd1);
      wait_left--;
    end else begin
      mwait = rnd_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    acc = mrd && !mwait;
    rv = 0;
    r_a = '0;
    r_stale = 0;
    if (!ret_block && pend.size() > 0 && pend[0].due <= cyc) begin
      e = pend.pop_front();
      rv = 1;
      r_a = e.a;
      r_stale = e.stale;
    end
    rvalid = rv;
    rdata = {2'b11, 11'd0, r_a};
    if (pr) begin
      if (model_q.size() > 0) begin
        exp_pix = model_q.pop_front();
        last_pix = exp_pix;
      end else begin
`ifdef BG_UNDERFLOW_HOLD_EN
        exp_pix = last_pix;
`else
        exp_pix = '0;
        last_pix = '0;
`endif
        exp_uf = 1'b1;
      end
    end
    if (f) foreach (pend[i]) pend[i].stale = 1;
    if (acc) begin
      e.due = cyc + LAT;
      e.a = maddr;
      e.stale = f || hold_stale;
      hold_stale = 0;
      if (!e.stale) begin
        check("rd_addr", 32'(maddr), 32'(exp_addr));
        exp_addr = exp_addr + 1'b1;
        acc_cnt++;
        if (acc_cnt == 1) first_acc = cyc;
        last_acc = cyc;
      end
      pend.push_back(e);
    end
    if (f) begin
      model_q.delete();
      exp_uf = 1'b0;
      hold_stale = mrd && mwait;
      exp_addr = BASE;
      acc_cnt = 0;
    end
    if (rv && !r_stale && !f) model_q.push_back({11'd0, r_a});
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (pr) check("pixel", {2'b00, vr, vg, vb}, {2'b00, exp_pix});
    check("uflow", 32'(uf), 32'(exp_uf));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    fs = 1'b0;
    mwait = 1'b0;
    rvalid = 1'b0;
    #1;
    check("rst_pix", {2'b00, vr, vg, vb}, 32'd0);
    check("rst_uflow", 32'(uf), 32'd0);
    check("rst_rd", 32'(mrd), 32'd0);
    check("rst_addr", 32'(maddr), 32'(BASE));
    pend.delete();
    model_q.delete();
    exp_uf = 1'b0;
    last_pix = '0;
    hold_stale = 0;
    wait_left = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // back-to-back burst limited by FIFO credit, then a whole frame in order
    tick(0, 1);
    check("rd_first", 32'(mrd), 32'd1);
    repeat (30) tick(0, 0);
    check("burst_cnt", 32'(acc_cnt), 32'd16);
    check("burst_b2b", 32'(last_acc - first_acc), 32'd15);
    check("credit_rd", 32'(mrd), 32'd0);
    repeat (H * V) tick(1, 0);
    tick(1, 0);
    repeat (5) tick(0, 0);
    check("frame_reads", 32'(acc_cnt), 32'(H * V));
    check("done_rd", 32'(mrd), 32'd0);

    // wait-request held on the third read
    stall_addr = BASE + 19'd2;
    stall_arm = 1;
    tick(0, 1);
    repeat (30) tick(0, 0);
    check("stall_cnt", 32'(acc_cnt), 32'd16);
    repeat (20) tick(1, 0);
    repeat (10) tick(0, 0);

    // restart with three reads outstanding and returns delayed
    ret_block = 1;
    tick(0, 1);
    tick(1, 0);
    tick(0, 0);
    tick(0, 1);
    repeat (3) tick(0, 0);
    check("drain_rd", 32'(mrd), 32'd0);
    check("drain_pend", 32'(pend.size()), 32'd3);
    ret_block = 0;
    repeat (30) tick(0, 0);
    check("restart_cnt", 32'(acc_cnt), 32'd16);
    tick(1, 0);

    // random stalls with concurrent push and pop
    tick(0, 1);
    repeat (20) tick(0, 0);
    tick(1, 0);
    rnd_wait = 1;
    repeat (100) tick(($urandom_range(0, 3) != 0), 0);
    rnd_wait = 0;
    repeat (20) tick(0, 0);

    // reset in the middle of fetching
    tick(0, 1);
    tick(0, 0);
    tick(1, 0);
    repeat (6) tick(0, 0);
    tick(1, 0);
    do_reset();
    tick(0, 1);
    repeat (25) tick(0, 0);
    tick(1, 0);
    check("post_rst_cnt", 32'(acc_cnt), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
